reaction_timer_core: RTL and testbench
======================================

// Module: reaction_timer_core
// PURPOSE
//  Reaction-timer control and measurement stage. Directly upstream of the four 7-segment decoders.
//  - After a start press, waits a pseudo-random delay, then lights the go LED.
//  - Counts elapsed milliseconds in 4-digit BCD until the stop press.
//  - Presents d3..d0 as 4-bit BCD codes (0-9 only) that the decoders consume unchanged.
//  - Detects false starts (stop before LED) and saturation at 9999 ms.
// PARAMETERS
//  TICK_DIV      50000   clk cycles per 1 ms tick (50 MHz clock)
//  DELAY_MIN_MS  1000    minimum random wait, ms
//  DELAY_MASK    16'h0FFF  AND-mask applied to LFSR for extra wait (0..4095 ms)
//  LFSR_SEED     16'hACE1  LFSR reset value; must be non-zero
// PORTS
//  clk          in   1  system clock
//  rst_n        in   1  asynchronous active-low reset
//  start        in   1  single-cycle pulse, already debounced/synchronised
//  stop         in   1  single-cycle pulse, already debounced/synchronised
//  led          out  1  go indicator; high only in TIMING
//  busy         out  1  high in WAIT or TIMING
//  false_start  out  1  sticky until next accepted start
//  overflow     out  1  sticky until next accepted start; count saturated
//  d3,d2,d1,d0  out  4  BCD digits, d3 = thousands ms, d0 = units ms
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, all outputs 0, digits 0, tick cnt 0, LFSR=LFSR_SEED.
//  Reset mid-run: immediate return to these values; no partial result retained.
//  All outputs registered. led/busy change 1 cycle after the triggering input edge.
//  LFSR: 16-bit Fibonacci, taps 16,14,13,11. Shifts every clk in all states; never 0.
//  Tick: counter 0..TICK_DIV-1, 1-cycle tick at wrap. Cleared on entry to WAIT and to TIMING.
//   First tick therefore arrives exactly TICK_DIV cycles after entry.
//  States:
//   IDLE    start -> WAIT. stop ignored.
//   WAIT    Entry: dly = DELAY_MIN_MS + (lfsr & DELAY_MASK); digits, false_start, overflow := 0.
//           Each tick: dly--. Tick with dly==1 -> TIMING.
//           stop -> DONE with false_start=1, digits stay 0000.
//           start ignored.
//   TIMING  led=1. Each tick: BCD increment d0 with ripple carry 9->0 to d1..d3.
//           Tick at 9999 -> no increment, overflow=1, -> DONE.
//           stop -> DONE, digits frozen. stop and tick in same cycle: stop wins, no increment.
//           start ignored.
//   DONE    led=0, busy=0, digits held. start -> WAIT (new run). stop ignored.
//  Digits never leave 0-9 (decoder defaults out-of-range codes to 0).
//  Width: dly is 16 bits; DELAY_MIN_MS+DELAY_MASK must be < 65536.
// STRUCTURE
//  Package reaction_pkg holds:
//   - state encoding IDLE=2'd0, WAIT=2'd1, TIMING=2'd2, DONE=2'd3
//   - LFSR taps and default seed
//   - BCD digit width (4)
//  Sub-module bcd_counter4: 4-digit BCD counter with clr, inc, and at_max flag.
//  FSM, tick divider and LFSR stay in this module.
// TESTING  (bench params TICK_DIV=4, DELAY_MIN_MS=3, DELAY_MASK=0)
//  1. start @ cycle 10 -> busy=1 @11; led=1 after 3 ticks (12 cycles); stop after 5 more ticks -> d=0005, led=0.
//  2. stop 2 ticks into WAIT -> false_start=1, d=0000, led never asserted; next start clears false_start.
//  3. No stop in TIMING -> digits reach 9999; next tick sets overflow=1, DONE, d holds 9999.
//  4. stop coincident with a TIMING tick at d=0041 -> d stays 0041.
//     Carry check: tick at 0099 -> 0100, tick at 0999 -> 1000.
//  5. rst_n low mid-TIMING at d=0123 -> all outputs 0 asynchronously; start after release runs normally.
//  6. start during WAIT/TIMING and stop in IDLE/DONE -> ignored.
//     DELAY_MASK=16'h0FFF: 8 runs give delays in [1000,5095] ms, not all equal.

Source files
------------

// File: rtl/reaction_pkg.sv
// Shared constants for the reaction timer: FSM encoding, LFSR taps/seed, BCD widths.
package reaction_pkg;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_TIMING = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // BCD display geometry
    localparam int         DIGIT_W    = 4;
    localparam int         NUM_DIGITS = 4;
    localparam logic [3:0] BCD_NINE   = 4'd9;

    // 16-bit Fibonacci LFSR, taps 16,14,13,11 -> bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

    // One LFSR step: shift left, feedback is the XOR of the tapped bits.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/bcd_counter4.sv
// Four-digit BCD up-counter with synchronous clear, saturating at 9999.
module bcd_counter4
    import reaction_pkg::*;
(
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             clr_i,
    input  logic                             inc_i,
    output logic [NUM_DIGITS*DIGIT_W-1:0]    digits_o,
    output logic                             at_max_o
);

    logic [NUM_DIGITS-1:0][DIGIT_W-1:0] dig_q, dig_d;

    assign at_max_o = (dig_q == {NUM_DIGITS{BCD_NINE}});
    assign digits_o = dig_q;

    // Ripple-carry BCD increment; clear has priority, increment is suppressed at 9999.
    always_comb begin
        logic carry;
        // NOTE: every signal driven in a combinational block gets a default first so no path infers a latch.
        dig_d = dig_q;
        carry = inc_i && !at_max_o;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (carry) begin
                if (dig_q[i] == BCD_NINE) begin
                    dig_d[i] = '0;
                end else begin
                    dig_d[i] = dig_q[i] + DIGIT_W'(1);
                    carry    = 1'b0;
                end
            end
        end
        if (clr_i) begin
            dig_d = '0;
        end
    end

    // Digit registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            dig_q <= '0;
        end else begin
            dig_q <= dig_d;
        end
    end

endmodule

// File: rtl/reaction_timer_core.sv
// Reaction timer: random wait, go LED, millisecond BCD measurement, false-start and overflow flags.
module reaction_timer_core
    import reaction_pkg::*;
#(
    parameter int          TICK_DIV     = 50000,
    parameter int          DELAY_MIN_MS = 1000,
    parameter logic [15:0] DELAY_MASK   = 16'h0FFF,
    parameter logic [15:0] LFSR_SEED    = LFSR_SEED_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    output logic       led,
    output logic       busy,
    output logic       false_start,
    output logic       overflow,
    output logic [3:0] d3,
    output logic [3:0] d2,
    output logic [3:0] d1,
    output logic [3:0] d0
);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [1:0]        state_q, state_d;
    logic [15:0]       lfsr_q;
    logic [TICK_W-1:0] tick_cnt_q;
    logic [15:0]       dly_q, dly_d;
    logic              led_q, busy_q, fs_q, fs_d, ov_q, ov_d;
    logic              tick, tick_clr, cnt_clr, cnt_inc, at_max;
    logic [15:0]       digits;

    assign tick = (tick_cnt_q == TICK_W'(TICK_DIV - 1));

    bcd_counter4 u_count (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (cnt_clr),
        .inc_i    (cnt_inc),
        .digits_o (digits),
        .at_max_o (at_max)
    );

    assign {d3, d2, d1, d0} = digits;
    assign led              = led_q;
    assign busy             = busy_q;
    assign false_start      = fs_q;
    assign overflow         = ov_q;

    // Free-running LFSR; it shifts in every state so the wait depends on when start is pressed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_q <= LFSR_SEED;
        else        lfsr_q <= lfsr_next(lfsr_q);
    end

    // Millisecond tick divider, restarted whenever WAIT or TIMING is entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)               tick_cnt_q <= '0;
        else if (tick_clr || tick) tick_cnt_q <= '0;
        else                      tick_cnt_q <= tick_cnt_q + TICK_W'(1);
    end

    // Next-state logic; stop is checked before tick so a coincident stop always wins.
    always_comb begin
        state_d  = state_q;
        dly_d    = dly_q;
        fs_d     = fs_q;
        ov_d     = ov_q;
        tick_clr = 1'b0;
        cnt_clr  = 1'b0;
        cnt_inc  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d  = ST_WAIT;
                    dly_d    = 16'(DELAY_MIN_MS) + (lfsr_q & DELAY_MASK);
                    fs_d     = 1'b0;
                    ov_d     = 1'b0;
                    tick_clr = 1'b1;
                    cnt_clr  = 1'b1;
                end
            end
            ST_WAIT: begin
                if (stop) begin
                    state_d = ST_DONE;
                    fs_d    = 1'b1;
                end else if (tick) begin
                    dly_d = dly_q - 16'd1;
                    if (dly_q == 16'd1) begin
                        state_d  = ST_TIMING;
                        tick_clr = 1'b1;
                    end
                end
            end
            ST_TIMING: begin
                if (stop) begin
                    state_d = ST_DONE;
                end else if (tick) begin
                    if (at_max) begin
                        ov_d    = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM, wait counter and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            dly_q   <= '0;
            led_q   <= 1'b0;
            busy_q  <= 1'b0;
            fs_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            dly_q   <= dly_d;
            led_q   <= (state_d == ST_TIMING);
            busy_q  <= (state_d == ST_WAIT) || (state_d == ST_TIMING);
            fs_q    <= fs_d;
            ov_q    <= ov_d;
        end
    end

endmodule

// File: tb/tb_reaction_timer_core.sv
// Self-checking bench for reaction_timer_core: directed table, hand sequences, random runs.
module tb_reaction_timer_core;

    localparam int T = 4;   // clk cycles per ms tick
    localparam int D = 3;   // wait in ms when the mask is zero

    logic clk = 1'b0, rst_n = 1'b0;
    logic start = 1'b0, stop = 1'b0, start_r = 1'b0, stop_r = 1'b0;
    logic led, busy, fs, ov, led_r, busy_r, fs_r, ov_r;
    logic [3:0] d3, d2, d1, d0, r3, r2, r1, r0;
    wire  [15:0] dig = {d3, d2, d1, d0};

    int n_cmp = 0, n_bad = 0;
    int cyc;   // rising edges since reset release

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    reaction_timer_core #(.TICK_DIV(T), .DELAY_MIN_MS(D), .DELAY_MASK(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .led(led), .busy(busy), .false_start(fs), .overflow(ov),
        .d3(d3), .d2(d2), .d1(d1), .d0(d0)
    );

    reaction_timer_core #(.TICK_DIV(1), .DELAY_MIN_MS(1000), .DELAY_MASK(16'h0FFF)) dut_r (
        .clk(clk), .rst_n(rst_n), .start(start_r), .stop(stop_r),
        .led(led_r), .busy(busy_r), .false_start(fs_r), .overflow(ov_r),
        .d3(r3), .d2(r2), .d1(r1), .d0(r0)
    );

    typedef struct {
        string       name;
        int          stop_at;   // edge of stop relative to the edge that accepted start
        logic [15:0] exp_d;
        logic        exp_fs;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_until(input int c);
        int g = 0;
        while (cyc < c && g < 50000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 50000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_until: cycle %0d never reached (at %0d)", c, cyc);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int n);
        return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
    endfunction

    // Reference for one run: stop at or before the LED edge is a false start,
    // otherwise the count is the number of ticks strictly before the stop edge.
    task automatic model_run(input int stop_at, output logic [15:0] d, output logic f);
        if (stop_at <= D * T) begin
            d = 16'h0000;
            f = 1'b1;
        end else begin
            d = to_bcd((stop_at - D * T - 1) / T);
            f = 1'b0;
        end
    endtask

    function automatic logic [15:0] lfsr_at(input int n);
        logic [15:0] s = 16'hACE1;
        for (int i = 0; i < n; i++) s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
        return s;
    endfunction

    // Start a run, optionally inject an (ignored) extra start, stop at a+stop_at.
    task automatic run_stop(input int stop_at, input int extra_start,
                            output logic [15:0] got_d, output logic got_fs, output logic led_seen);
        int a;
        @(negedge clk);
        start = 1'b1;
        a = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        led_seen = 1'b0;
        while (cyc + 1 < a + stop_at) begin
            start = (extra_start > 0) && (cyc + 1 == a + extra_start);
            @(negedge clk);
            led_seen |= led;
        end
        start = 1'b0;
        stop  = 1'b1;
        @(negedge clk);
        stop   = 1'b0;
        got_d  = dig;
        got_fs = fs;
    endtask

    task automatic pulse_stop_in_done(input logic [15:0] exp_d, input logic exp_fs);
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        @(negedge clk);
        check("stop_ignored_digits", dig, exp_d);
        check("stop_ignored_fs_busy", {fs, busy}, {exp_fs, 1'b0});
    endtask

    initial begin
        #1_200_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] gd, ed;
        logic        gf, ef, ls;
        int          a, e, k, n, first_dly;
        logic        all_same;

        vecs[0] = '{"wait_2_ticks",      8,           16'h0000, 1'b1};
        vecs[1] = '{"stop_at_led_edge",  D * T,       16'h0000, 1'b1};
        vecs[2] = '{"stop_right_after",  D * T + 1,   16'h0000, 1'b0};
        vecs[3] = '{"five_ticks",        D * T + 21,  16'h0005, 1'b0};
        vecs[4] = '{"stop_on_5th_tick",  D * T + 20,  16'h0004, 1'b0};
        vecs[5] = '{"stop_on_tick_0041", D * T + 168, 16'h0041, 1'b0};
        vecs[6] = '{"carry_0099_0100",   D * T + 401, 16'h0100, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_outputs", {led, busy, fs, ov, dig}, 20'h0);
        check("reset_outputs_r", {led_r, busy_r, fs_r, ov_r, r3, r2, r1, r0}, 20'h0);
        rst_n = 1'b1;

        // Start sampled at edge 10: busy from 10, LED after 3 ticks (edge 22), stop after 5 ticks
        wait_until(9);
        check("busy_before_start", busy, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", {busy, led}, 2'b10);
        wait_until(21);
        check("led_before_3_ticks", led, 1'b0);
        wait_until(22);
        check("led_after_3_ticks", {led, busy}, 2'b11);
        wait_until(42);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("first_run_result", {led, busy, fs, ov, dig}, {4'b0000, 16'h0005});

        // Directed table
        for (int i = 0; i < 7; i++) begin
            run_stop(vecs[i].stop_at, 0, gd, gf, ls);
            check({vecs[i].name, "_digits"}, gd, vecs[i].exp_d);
            check({vecs[i].name, "_fs"}, gf, vecs[i].exp_fs);
            check({vecs[i].name, "_led_seen"}, ls, !vecs[i].exp_fs);
            check({vecs[i].name, "_idle"}, {led, busy}, 2'b00);
        end

        // False start is cleared by the next accepted start
        run_stop(8, 0, gd, gf, ls);
        check("false_start_set", gf, 1'b1);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("false_start_cleared", {fs, busy}, 2'b01);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("false_start_again", {fs, dig}, {1'b1, 16'h0000});

        // Random runs against the model, with ignored extra starts and ignored stops in DONE
        for (int i = 0; i < 16; i++) begin
            int sa, xs;
            sa = $urandom_range(1, D * T + 160);
            xs = (sa > 2 && $urandom_range(0, 1) == 1) ? $urandom_range(1, sa - 1) : 0;
            model_run(sa, ed, ef);
            run_stop(sa, xs, gd, gf, ls);
            check("rand_digits", gd, ed);
            check("rand_fs", gf, ef);
            if ($urandom_range(0, 1) == 1) pulse_stop_in_done(ed, ef);
            repeat ($urandom_range(0, 5)) @(negedge clk);
        end

        // Long run: carries, ignored start in TIMING, saturation at 9999 and overflow
        @(negedge clk);
        start = 1'b1;
        a = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        e = a + D * T;
        wait_until(e + T * 99);
        check("count_0099", dig, 16'h0099);
        wait_until(e + T * 100);
        check("carry_to_0100", dig, 16'h0100);
        wait_until(e + 1999);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_ignored_timing", {led, busy}, 2'b11);
        wait_until(e + T * 999);
        check("count_0999", dig, 16'h0999);
        wait_until(e + T * 1000);
        check("carry_to_1000", dig, 16'h1000);
        wait_until(e + T * 9999);
        check("count_9999", {led, busy, ov, dig}, {3'b110, 16'h9999});
        wait_until(e + T * 10000);
        check("overflow_done", {led, busy, fs, ov, dig}, {4'b0001, 16'h9999});
        wait_until(e + T * 10000 + 10);
        check("overflow_hold", {ov, dig}, {1'b1, 16'h9999});
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("stop_ignored_after_ovf", {ov, dig}, {1'b1, 16'h9999});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("new_start_clears", {busy, ov, dig}, {2'b10, 16'h0000});
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;

        // Asynchronous reset in the middle of TIMING
        @(negedge clk);
        start = 1'b1;
        a = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        wait_until(a + D * T + T * 123);
        check("pre_reset_0123", {led, busy, dig}, {2'b11, 16'h0123});
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {led, busy, fs, ov, dig}, 20'h0);
        @(negedge clk);
        rst_n = 1'b1;
        run_stop(D * T + 21, 0, gd, gf, ls);
        check("after_reset_run", {gf, gd}, {1'b0, 16'h0005});

        // Full-mask LFSR delays on the second instance (1 clk per ms)
        all_same  = 1'b1;
        first_dly = -1;
        for (int i = 0; i < 8; i++) begin
            int exp_dly;
            @(negedge clk);
            start_r = 1'b1;
            n = cyc;
            @(negedge clk);
            start_r = 1'b0;
            k = 1;
            while (!led_r && k < 6000) begin
                @(negedge clk);
                k++;
            end
            exp_dly = 1000 + int'(lfsr_at(n) & 16'h0FFF);
            check("lfsr_delay", k - 1, exp_dly);
            check("lfsr_delay_range", ((k - 1) >= 1000) && ((k - 1) <= 5095), 1'b1);
            if (first_dly < 0) first_dly = k - 1;
            else if (k - 1 != first_dly) all_same = 1'b0;
            stop_r = 1'b1;
            @(negedge clk);
            stop_r = 1'b0;
            repeat ($urandom_range(0, 40)) @(negedge clk);
        end
        check("lfsr_delays_vary", all_same, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
